// File: rtl/wave_analyzer_pkg.sv
// Shared encodings for the waveform analyzer: sample width, wave-type codes,
// FSM states, per-window delta flags and the shape classifier.
package wave_analyzer_pkg;

  localparam int SAMPLE_W = 5;

  localparam logic [1:0] WT_SQUARE = 2'd0;
  localparam logic [1:0] WT_SAW    = 2'd1;
  localparam logic [1:0] WT_TRI    = 2'd2;
  localparam logic [1:0] WT_UNK    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  typedef logic [SAMPLE_W-1:0]      sample_t;
  typedef logic signed [SAMPLE_W:0] delta_t;

  typedef struct packed {
    logic pos1;
    logic neg1;
    logic bigp;
    logic bign;
  } flags_t;

  // Rule order matters: the first matching shape wins.
  function automatic logic [1:0] classify(input flags_t f);
    if (f.bigp && f.bign && !f.pos1 && !f.neg1) return WT_SQUARE;
    if (f.pos1 && f.bign && !f.neg1 && !f.bigp) return WT_SAW;
    if (f.pos1 && f.neg1 && !f.bigp && !f.bign) return WT_TRI;
    return WT_UNK;
  endfunction

endpackage

// File: rtl/wave_window_stats.sv
// Running max/min and step-size flags for one measurement window.
// Latency: registered, 1 cycle; flags_cls already folds in the current delta.
// Backpressure: none, a sample arrives every cycle.
module wave_window_stats
  import wave_analyzer_pkg::*;
#(
  parameter int BIG_STEP = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    seed,
  input  logic    upd,
  input  sample_t wave,
  input  delta_t  delta,
  output sample_t run_max,
  output sample_t run_min,
  output flags_t  flags_cls
);

  localparam delta_t BIG_P = delta_t'(BIG_STEP);
  localparam delta_t BIG_N = -BIG_P;

  flags_t cur;
  flags_t win_flags;

  always_comb begin
    cur      = '0;
    cur.pos1 = (delta == 6'sd1);
    cur.neg1 = (delta == -6'sd1);
    cur.bigp = (delta >= BIG_P);
    cur.bign = (delta <= BIG_N);
  end

  // The closing step into the next anchor belongs to the window being closed.
  assign flags_cls = win_flags | cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max   <= '0;
      run_min   <= '1;
      win_flags <= '0;
    end else if (seed) begin
      run_max   <= wave;
      run_min   <= wave;
      win_flags <= '0;
    end else if (upd) begin
      if (wave > run_max) run_max <= wave;
      if (wave < run_min) run_min <= wave;
      win_flags <= win_flags | cur;
    end
  end

endmodule

// File: rtl/wave_analyzer.sv
// Splits the wave stream into periods at rising-after-non-rising anchors, reports period/peak/trough and shape, and locks once stable.
// Latency: results register on the anchor edge, visible the next cycle.
// Backpressure: none, wave is sampled every cycle.
module wave_analyzer
  import wave_analyzer_pkg::*;
#(
  parameter int PW       = 8,
  parameter int LOCK_CNT = 2,
  parameter int BIG_STEP = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] wave,
  output logic [1:0]          wave_type,
  output logic                locked,
  output logic [PW-1:0]       period,
  output logic [SAMPLE_W-1:0] peak,
  output logic [SAMPLE_W-1:0] trough,
  output logic                win_done
);

  localparam int          MW      = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [PW-1:0] CNT_MAX = '1;
  localparam logic [MW-1:0] MATCH_TOP = MW'(LOCK_CNT);

  state_t        state;
  sample_t       wave_prev;
  delta_t        prev_delta;
  delta_t        delta;
  logic [PW-1:0] cnt;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] next_match;
  logic          have_ref;
  logic [1:0]    ref_type;
  logic [PW-1:0] ref_period;
  logic          anchor;
  logic          in_window;
  logic          stats_seed;
  logic          stats_upd;
  logic [1:0]    new_type;
  sample_t       run_max;
  sample_t       run_min;
  flags_t        flags_cls;

  assign delta     = $signed({1'b0, wave}) - $signed({1'b0, wave_prev});
  assign anchor    = (delta > 6'sd0) && (prev_delta <= 6'sd0);
  assign in_window = (state == ST_MEAS);

  assign stats_seed = !clear && anchor && ((state == ST_SEEK) || in_window);
  assign stats_upd  = !clear && !anchor && in_window;
  assign new_type   = classify(flags_cls);

  // Only a known shape with an unchanged period extends the match streak.
  always_comb begin
    next_match = '0;
    if (have_ref && (new_type == ref_type) && (cnt == ref_period) && (new_type != WT_UNK))
      next_match = (match_cnt == MATCH_TOP) ? match_cnt : match_cnt + 1'b1;
  end

  wave_window_stats #(
    .BIG_STEP (BIG_STEP)
  ) u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed      (stats_seed),
    .upd       (stats_upd),
    .wave      (wave),
    .delta     (delta),
    .run_max   (run_max),
    .run_min   (run_min),
    .flags_cls (flags_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wave_prev  <= '0;
      prev_delta <= '0;
      cnt        <= '0;
      match_cnt  <= '0;
      have_ref   <= 1'b0;
      ref_type   <= WT_UNK;
      ref_period <= '0;
      wave_type  <= WT_UNK;
      locked     <= 1'b0;
      period     <= '0;
      peak       <= '0;
      trough     <= '1;
      win_done   <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (clear) begin
        state     <= ST_IDLE;
        locked    <= 1'b0;
        match_cnt <= '0;
        have_ref  <= 1'b0;
        wave_type <= WT_UNK;
      end else begin
        case (state)
          ST_IDLE: begin
            wave_prev  <= wave;
            prev_delta <= '0;
            state      <= ST_SEEK;
          end
          ST_SEEK: begin
            wave_prev  <= wave;
            prev_delta <= delta;
            if (anchor) begin
              cnt   <= PW'(1);
              state <= ST_MEAS;
            end
          end
          ST_MEAS: begin
            wave_prev  <= wave;
            prev_delta <= delta;
            if (anchor) begin
              win_done   <= 1'b1;
              period     <= cnt;
              peak       <= run_max;
              trough     <= run_min;
              wave_type  <= new_type;
              match_cnt  <= next_match;
              locked     <= (next_match == MATCH_TOP);
              have_ref   <= 1'b1;
              ref_type   <= new_type;
              ref_period <= cnt;
              cnt        <= PW'(1);
            end else if (cnt == CNT_MAX) begin
              // No anchor within a full count: report what we have and re-acquire.
              win_done  <= 1'b1;
              period    <= cnt;
              peak      <= run_max;
              trough    <= run_min;
              wave_type <= WT_UNK;
              locked    <= 1'b0;
              match_cnt <= '0;
              have_ref  <= 1'b0;
              state     <= ST_SEEK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_analyzer.sv
// Randomized scoreboard bench for wave_analyzer: a list-based window model
// predicts each window close; a negedge monitor pops and compares.
module tb_wave_analyzer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] wave = '0;
  logic [1:0] wave_type;
  logic       locked;
  logic [7:0] period;
  logic [4:0] peak;
  logic [4:0] trough;
  logic       win_done;

  wave_analyzer #(.PW(8), .LOCK_CNT(2), .BIG_STEP(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .wave      (wave),
    .wave_type (wave_type),
    .locked    (locked),
    .period    (period),
    .peak      (peak),
    .trough    (trough),
    .win_done  (win_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int l;
    int p;
    int pk;
    int tr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: phase 0 idle, 1 searching, 2 inside a window.
  int ms, prev_s, prev_d;
  int win[$];
  int have_ref, ref_t, ref_p, match;
  int m_type, m_locked, m_period, m_peak, m_trough;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; prev_s = 0; prev_d = 0; win.delete();
    have_ref = 0; ref_t = 3; ref_p = 0; match = 0;
    m_type = 3; m_locked = 0; m_period = 0; m_peak = 0; m_trough = 31;
  endtask

  task automatic close_window(input int w, input bit timeout);
    exp_t e;
    int pk, tr, t, nxt, dd;
    bit p1, n1, bp, bn;
    pk = 0; tr = 31; p1 = 0; n1 = 0; bp = 0; bn = 0;
    for (int i = 0; i < win.size(); i++) begin
      if (win[i] > pk) pk = win[i];
      if (win[i] < tr) tr = win[i];
      nxt = (i + 1 < win.size()) ? win[i+1] : w;
      dd = nxt - win[i];
      if (dd == 1) p1 = 1;
      if (dd == -1) n1 = 1;
      if (dd >= 2) bp = 1;
      if (dd <= -2) bn = 1;
    end
    if (timeout) t = 3;
    else if (bp && bn && !p1 && !n1) t = 0;
    else if (p1 && bn && !n1 && !bp) t = 1;
    else if (p1 && n1 && !bp && !bn) t = 2;
    else t = 3;
    if (!timeout && have_ref && t == ref_t && win.size() == ref_p && t != 3)
      match = (match < 2) ? match + 1 : 2;
    else
      match = 0;
    m_locked = (match == 2);
    if (timeout) begin
      have_ref = 0;
    end else begin
      have_ref = 1; ref_t = t; ref_p = win.size();
    end
    m_type = t; m_period = win.size(); m_peak = pk; m_trough = tr;
    e.t = t; e.l = m_locked; e.p = m_period; e.pk = pk; e.tr = tr;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input int w, input bit clr);
    int d;
    bit anch;
    if (clr) begin
      ms = 0; match = 0; m_locked = 0; m_type = 3; have_ref = 0;
      return;
    end
    if (ms == 0) begin
      prev_s = w; prev_d = 0; ms = 1;
      return;
    end
    d = w - prev_s;
    anch = (d > 0) && (prev_d <= 0);
    if (ms == 1) begin
      if (anch) begin win.delete(); win.push_back(w); ms = 2; end
    end else if (anch) begin
      close_window(w, 1'b0);
      win.delete(); win.push_back(w);
    end else if (win.size() == 255) begin
      close_window(w, 1'b1);
      ms = 1;
    end else begin
      win.push_back(w);
    end
    prev_s = w; prev_d = d;
  endtask

  task automatic drive(input int w, input bit clr);
    wave = 5'(w);
    clear = clr;
    model_step(w, clr);
    @(posedge clk);
    #1;
  endtask

  // kind 0 square, 1 sawtooth, 2 triangle
  function automatic int sample_at(input int kind, input int amp, input int half, input int ph);
    int m;
    if (kind == 0) return ((ph % (2 * half)) < half) ? 0 : amp;
    if (kind == 1) return ph % (amp + 1);
    m = ph % (2 * amp);
    return (m <= amp) ? m : 2 * amp - m;
  endfunction

  task automatic run_wave(input int kind, input int amp, input int half, input int ncyc);
    for (int ph = 0; ph < ncyc; ph++) drive(sample_at(kind, amp, half, ph), 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_type"}, wave_type, 3);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_peak"}, peak, 0);
    chk({tag, "_trough"}, trough, 31);
    chk({tag, "_win_done"}, win_done, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && win_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_win_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("win_type", wave_type, e.t);
        chk("win_locked", locked, e.l);
        chk("win_period", period, e.p);
        chk("win_peak", peak, e.pk);
        chk("win_trough", trough, e.tr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected under 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Square 0/20, half 10: locks on the third close; stop mid-high-half.
    run_wave(0, 20, 10, 95);
    // Switch to sawtooth mid-period: one bad window, then relock as type 1.
    run_wave(1, 20, 0, 150);
    run_wave(2, 20, 0, 200);

    for (int k = 0; k < 6; k++) begin
      int kind, amp, half, ncyc;
      kind = $urandom_range(0, 2);
      amp  = $urandom_range(2, 31);
      half = $urandom_range(2, 15);
      ncyc = $urandom_range(80, 200);
      run_wave(kind, amp, half, ncyc);
    end

    for (int k = 0; k < 150; k++) drive($urandom_range(0, 31), 1'b0);

    // Enter a window, then hold flat long enough to hit the count ceiling.
    drive(3, 1'b0); drive(1, 1'b0); drive(7, 1'b0);
    for (int k = 0; k < 300; k++) drive(7, 1'b0);

    // Synchronous clear mid-window.
    run_wave(0, 20, 10, 75);
    drive(20, 1'b1);
    chk("clear_locked", locked, 0);
    chk("clear_type", wave_type, 3);
    chk("clear_period_hold", period, m_period);
    chk("clear_peak_hold", peak, m_peak);
    chk("clear_trough_hold", trough, m_trough);
    chk("clear_win_done", win_done, 0);
    run_wave(1, 12, 0, 70);

    // Asynchronous reset pulse mid-window, checked without a clock edge.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    exp_q.delete();
    model_reset();
    #2;
    rst_n = 1'b1;
    run_wave(1, 9, 0, 60);

    for (int k = 0; k < 3; k++) drive(0, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
